bmp_assembler: RTL and testbench

- Deserializer that feeds the compare accelerator.
- Accepts 64-bit bitmap columns from an upstream producer over a valid/ready handshake and packs them into a 1536-bit bitmap (24 columns x 64 bits).
- Issues a one-cycle write strobe with the bitmap to the accelerator, waits for its done, and captures the 13-bit result for the host side.
- This is the write-side counterpart of the accelerator's internal column/row serializer.

---
 rtl/cmpacc_pkg.sv | 35 +++
 rtl/col_popcount.sv | 33 +++
 rtl/bmp_assembler.sv | 199 +++++++++++++++++++
 tb/tb_bmp_assembler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmpacc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmpacc_pkg
//  Description : Shared constants and types for the compare-accelerator
//                bitmap path. Holds the bitmap geometry (columns, column
//                width, derived bitmap width), the compare result width,
//                the column-index width and the assembler state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package cmpacc_pkg;

    // Bitmap geometry: 24 columns of 64 rows each.
    localparam int C_COLS   = 24;
    localparam int C_COL_W  = 64;
    localparam int C_BMP_W  = C_COLS * C_COL_W;   // 1536

    // Compare result width produced by the accelerator.
    localparam int C_RES_W  = 13;

    // Column index width; holds 0..C_COLS-1.
    localparam int C_CIDX_W = 5;

    // Ones count of a full bitmap (max 1536) and of a single column (max 64).
    localparam int C_POP_W  = 11;
    localparam int C_CPOP_W = 7;

    // Assembler state encoding.
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_EMIT = 2'd1,
        ST_WAIT = 2'd2
    } asm_state_t;

endpackage : cmpacc_pkg
`default_nettype wire

// File: rtl/col_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : col_popcount
//  Description : Combinational ones counter for one bitmap column.
//                Only instantiated when BMPASM_POPCNT_EN is defined.
//  Ports       : i_data  [W-1:0]      column word
//                o_count [CNT_W-1:0]  number of set bits in i_data
//  Revision    : 1.0  initial release
// ============================================================================
module col_popcount
    import cmpacc_pkg::*;
#(
    parameter int W     = C_COL_W,
    parameter int CNT_W = C_CPOP_W
) (
    input  logic [W-1:0]     i_data,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] w_sum;

    // Plain ripple of 1-bit adds; synthesis rebalances this into a tree.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < W; i++) begin
            w_sum = w_sum + CNT_W'(i_data[i]);
        end
    end

    assign o_count = w_sum;

endmodule : col_popcount
`default_nettype wire

// File: rtl/bmp_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : bmp_assembler
//  Description : Column deserializer feeding the compare accelerator.
//                Accepts 64-bit columns over valid/ready, packs up to 24 of
//                them into a 1536-bit bitmap, strobes the bitmap into the
//                accelerator for one cycle, waits for its done and captures
//                the 13-bit result.
//
//  Build option: BMPASM_POPCNT_EN -- when defined, pop_count accumulates the
//                ones count of the frame; otherwise pop_count is tied to 0.
//
//  Ports       : clk          system clock, rising edge
//                rst          synchronous active-high reset
//                col_data     column word, bit r = row r
//                col_valid    col_data valid
//                col_last     col_data is the final column of the frame
//                col_ready    assembler can accept a column (FILL only)
//                bmp_out      assembled bitmap, column c at [c*COL_W +: COL_W]
//                bmp_wren     one-cycle write strobe to the accelerator
//                cmp_done     accelerator done
//                cmp_result   accelerator result, valid with cmp_done
//                result_out   captured result
//                result_valid one-cycle pulse when result_out updates
//                short_frame  pulse with bmp_wren when the frame ended early
//                pop_count    ones count of the frame (optional)
//  Revision    : 1.0  initial release
// ============================================================================
module bmp_assembler
    import cmpacc_pkg::*;
#(
    parameter int COLS  = C_COLS,
    parameter int COL_W = C_COL_W,
    parameter int RES_W = C_RES_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COL_W-1:0]      col_data,
    input  logic                  col_valid,
    input  logic                  col_last,
    output logic                  col_ready,
    output logic [COLS*COL_W-1:0] bmp_out,
    output logic                  bmp_wren,
    input  logic                  cmp_done,
    input  logic [RES_W-1:0]      cmp_result,
    output logic [RES_W-1:0]      result_out,
    output logic                  result_valid,
    output logic                  short_frame,
    output logic [C_POP_W-1:0]    pop_count
);

    localparam int                  BMP_W      = COLS * COL_W;
    localparam logic [C_CIDX_W-1:0] C_LAST_IDX = C_CIDX_W'(COLS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    asm_state_t            r_state;
    asm_state_t            w_state_nxt;
    logic [C_CIDX_W-1:0]   r_col_idx;
    logic [BMP_W-1:0]      r_bmp;
    logic [RES_W-1:0]      r_result;
    logic                  r_result_valid;
    logic                  r_short;       // frame closed by an early col_last

    logic                  w_xfer;        // column accepted this cycle
    logic                  w_frame_end;   // accepted column closes the frame
    logic                  w_done_ack;    // accelerator finished our bitmap

    assign w_xfer      = col_valid && col_ready;
    assign w_frame_end = col_last || (r_col_idx == C_LAST_IDX);
    // cmp_done only counts in WAIT; in FILL or EMIT it is a stray pulse.
    assign w_done_ack  = (r_state == ST_WAIT) && cmp_done;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_xfer && w_frame_end) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cmp_done) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (Moore, state-decoded)
    // ------------------------------------------------------------------
    always_comb begin
        col_ready   = 1'b0;
        bmp_wren    = 1'b0;
        short_frame = 1'b0;
        case (r_state)
            ST_FILL: col_ready = 1'b1;
            ST_EMIT: begin
                bmp_wren    = 1'b1;
                short_frame = r_short;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Column packing and result capture
    // ------------------------------------------------------------------
    // Columns above an early col_last stay zero because the bitmap is
    // cleared when the previous frame is retired (and on reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_idx      <= '0;
            r_bmp          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_short        <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_xfer) begin
                r_bmp[r_col_idx*COL_W +: COL_W] <= col_data;
                if (w_frame_end) begin
                    // Index is held at the closing column so it never
                    // passes COLS-1; it is rewound when the frame retires.
                    r_short <= col_last && (r_col_idx != C_LAST_IDX);
                end else begin
                    r_col_idx <= r_col_idx + C_CIDX_W'(1);
                end
            end
            if (w_done_ack) begin
                r_result       <= cmp_result;
                r_result_valid <= 1'b1;
                r_bmp          <= '0;
                r_col_idx      <= '0;
                r_short        <= 1'b0;
            end
        end
    end

    assign bmp_out      = r_bmp;
    assign result_out   = r_result;
    assign result_valid = r_result_valid;

    // ------------------------------------------------------------------
    // Optional frame ones count
    // ------------------------------------------------------------------
`ifdef BMPASM_POPCNT_EN
    logic [C_CPOP_W-1:0] w_col_ones;
    logic [C_POP_W-1:0]  r_pop;

    col_popcount #(
        .W     (COL_W),
        .CNT_W (C_CPOP_W)
    ) u_col_popcount (
        .i_data  (col_data),
        .o_count (w_col_ones)
    );

    // Accumulates only on accepted columns, so the value is final in EMIT
    // and naturally held through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pop <= '0;
        end else if (w_done_ack) begin
            r_pop <= '0;
        end else if (w_xfer) begin
            r_pop <= r_pop + C_POP_W'(w_col_ones);
        end
    end

    assign pop_count = r_pop;
`else
    assign pop_count = '0;
`endif

endmodule : bmp_assembler
`default_nettype wire

// File: tb/tb_bmp_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bmp_assembler
//  Description : Self-checking bench for bmp_assembler. Table-driven frames
//                plus hand-written corner sequences; expected bitmaps and
//                results are queued when stimulus is driven and compared by
//                a monitor when the DUT strobes bmp_wren / result_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bmp_assembler;

    localparam int COLS  = 24;
    localparam int COL_W = 64;
    localparam int RES_W = 13;
    localparam int BMP_W = COLS * COL_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [COL_W-1:0]  col_data;
    logic              col_valid;
    logic              col_last;
    logic              col_ready;
    logic [BMP_W-1:0]  bmp_out;
    logic              bmp_wren;
    logic              cmp_done;
    logic [RES_W-1:0]  cmp_result;
    logic [RES_W-1:0]  result_out;
    logic              result_valid;
    logic              short_frame;
    logic [10:0]       pop_count;

    always #5 clk = ~clk;

    bmp_assembler dut (
        .clk          (clk),
        .rst          (rst),
        .col_data     (col_data),
        .col_valid    (col_valid),
        .col_last     (col_last),
        .col_ready    (col_ready),
        .bmp_out      (bmp_out),
        .bmp_wren     (bmp_wren),
        .cmp_done     (cmp_done),
        .cmp_result   (cmp_result),
        .result_out   (result_out),
        .result_valid (result_valid),
        .short_frame  (short_frame),
        .pop_count    (pop_count)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [BMP_W-1:0] bmp;
        logic             sf;
        logic [10:0]      pc;
    } frm_t;

    frm_t        q_frm[$];
    logic [12:0] q_res[$];
    int checks   = 0;
    int failures = 0;
    int wren_cnt = 0;
    int rv_cnt   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] coldat(input int kind, input int seed, input int c);
        logic [31:0] a;
        logic [31:0] b;
        case (kind)
            0:       return {32'hC0DE0000 | 32'(c), 32'h0};
            1:       return {64{1'b1}};
            default: begin
                a = 32'(seed) * 32'h9E3779B9 ^ 32'(c * 7 + 1) * 32'h85EBCA6B;
                b = ~a ^ (32'(c) << 5) ^ 32'(seed * 3);
                return {a, b};
            end
        endcase
    endfunction

    function automatic logic [BMP_W-1:0] model_bmp(input int kind, input int seed, input int ncols);
        logic [BMP_W-1:0] m;
        m = '0;
        for (int c = 0; c < ncols; c++) m[c*COL_W +: COL_W] = coldat(kind, seed, c);
        return m;
    endfunction

    function automatic int model_pc(input int kind, input int seed, input int ncols);
        int s;
        s = 0;
        for (int c = 0; c < ncols; c++) s += $countones(coldat(kind, seed, c));
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compares on DUT events, sampled on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin : mon
        frm_t e;
        int   bad;
        if (!rst) begin
            if (bmp_wren) begin
                wren_cnt++;
                if (q_frm.size() == 0) begin
                    chk("unexpected_bmp_wren", 64'(bmp_wren), 64'd0);
                end else begin
                    e   = q_frm.pop_front();
                    bad = -1;
                    for (int c = 0; c < COLS; c++)
                        if (bad < 0 && bmp_out[c*COL_W +: COL_W] !== e.bmp[c*COL_W +: COL_W]) bad = c;
                    checks++;
                    if (bad >= 0) begin
                        failures++;
                        $display("FAIL bitmap col=%0d actual=%h required=%h",
                                 bad, bmp_out[bad*COL_W +: COL_W], e.bmp[bad*COL_W +: COL_W]);
                    end
                    chk("short_frame", 64'(short_frame), 64'(e.sf));
                    chk("pop_count", 64'(pop_count), 64'(e.pc));
                end
            end else if (short_frame) begin
                chk("short_without_wren", 64'(short_frame), 64'(bmp_wren));
            end
            if (result_valid) begin
                rv_cnt++;
                chk("rv_after_wren", 64'(rv_cnt <= wren_cnt), 64'd1);
                if (q_res.size() == 0)
                    chk("unexpected_result_valid", 64'(result_valid), 64'd0);
                else
                    chk("result_out", 64'(result_out), 64'(q_res.pop_front()));
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (always entered/left at 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic xfer_col(input logic [63:0] d, input logic l, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        col_valid = 1'b1;
        col_data  = d;
        col_last  = l;
        n = 0;
        while (!col_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk("col_ready_timeout", 64'(col_ready), 64'd1);
        @(posedge clk); #1;
        col_valid = 1'b0;
        col_last  = 1'b0;
    endtask

    task automatic send_frame(input int ncols, input bit last, input int kind, input int seed,
                              input int gap_max, input int start, input bit exp_sf,
                              input int exp_pc, input bit complete);
        frm_t e;
        e.bmp = model_bmp(kind, seed, ncols);
        e.sf  = exp_sf;
`ifdef BMPASM_POPCNT_EN
        e.pc  = 11'(exp_pc);
`else
        e.pc  = 11'd0;
`endif
        for (int c = start; c < ncols; c++) begin
            if (complete && c == ncols - 1) q_frm.push_back(e);
            xfer_col(coldat(kind, seed, c), (c == ncols - 1) && last,
                     int'($urandom_range(gap_max, 0)));
        end
        if (complete) chk("wren_latency", 64'(bmp_wren), 64'd1);
    endtask

    // Entered in the EMIT cycle (or later in WAIT).
    task automatic finish_done(input logic [12:0] res, input int delay);
        repeat (delay + 1) begin @(posedge clk); #1; end
        cmp_result = res;
        cmp_done   = 1'b1;
        q_res.push_back(res);
        @(posedge clk); #1;
        cmp_done = 1'b0;
        chk("result_valid_latency", 64'(result_valid), 64'd1);
        chk("ready_after_done", 64'(col_ready), 64'd1);
        chk("result_out_now", 64'(result_out), 64'(res));
    endtask

    // ------------------------------------------------------------------
    // Stimulus table
    // ------------------------------------------------------------------
    typedef struct {
        int          ncols;
        bit          last;
        int          kind;
        int          seed;
        logic [12:0] res;
        bit          exp_sf;
        int          exp_pc;
    } vec_t;

    vec_t vt[5];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [BMP_W-1:0] snap;
        int w0, ncols;
        bit last;

        vt[0] = '{24, 1'b1, 0, 0, 13'h0A5,  1'b0, 244};   // full frame, normal end
        vt[1] = '{5,  1'b1, 1, 0, 13'h1FFF, 1'b1, 320};   // short frame, all ones
        vt[2] = '{24, 1'b0, 1, 0, 13'h000,  1'b0, 1536};  // no col_last at all
        vt[3] = '{1,  1'b1, 1, 0, 13'h001,  1'b1, 64};    // single-column frame
        vt[4] = '{23, 1'b1, 1, 0, 13'h123,  1'b1, 1472};  // one short of full

        rst = 1'b1; col_data = '0; col_valid = 1'b0; col_last = 1'b0;
        cmp_done = 1'b0; cmp_result = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_col_ready", 64'(col_ready), 64'd1);
        chk("rst_bmp_wren", 64'(bmp_wren), 64'd0);
        chk("rst_bmp_out_zero", 64'(bmp_out == '0), 64'd1);
        chk("rst_result_out", 64'(result_out), 64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_short_frame", 64'(short_frame), 64'd0);
        chk("rst_pop_count", 64'(pop_count), 64'd0);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            send_frame(vt[i].ncols, vt[i].last, vt[i].kind, vt[i].seed, 0, 0,
                       vt[i].exp_sf, vt[i].exp_pc, 1'b1);
            if (vt[i].ncols == 5)
                chk("short_upper_zero", 64'(bmp_out[BMP_W-1:320] == '0), 64'd1);
            finish_done(vt[i].res, i);
        end

        // Backpressure in WAIT; first transfer in the result_valid cycle
        send_frame(24, 1'b1, 2, 7, 1, 0, 1'b0, model_pc(2, 7, 24), 1'b1);
        snap      = model_bmp(2, 7, 24);
        col_valid = 1'b1;
        col_data  = coldat(2, 8, 0);
        col_last  = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            chk("bp_col_ready_low", 64'(col_ready), 64'd0);
            chk("bp_bmp_held", 64'(bmp_out === snap), 64'd1);
        end
        cmp_result = 13'h0BB;
        cmp_done   = 1'b1;
        q_res.push_back(13'h0BB);
        @(posedge clk); #1;
        cmp_done = 1'b0;
        chk("bp_rv_and_ready", 64'({result_valid, col_ready}), 64'd3);
        @(posedge clk); #1;          // column 0 of the next frame transfers here
        col_valid = 1'b0;
        send_frame(6, 1'b1, 2, 8, 0, 1, 1'b1, model_pc(2, 8, 6), 1'b1);
        finish_done(13'h0CC, 1);

        // Stray done in FILL and in EMIT
        cmp_result = 13'h0F0;
        cmp_done   = 1'b1;
        @(posedge clk); #1;
        cmp_done = 1'b0;
        chk("stray_fill_ready", 64'(col_ready), 64'd1);
        chk("stray_fill_no_rv", 64'(result_valid), 64'd0);
        send_frame(8, 1'b1, 2, 9, 0, 0, 1'b1, model_pc(2, 9, 8), 1'b1);
        cmp_done = 1'b1;               // arrives in the EMIT cycle
        @(posedge clk); #1;
        cmp_done = 1'b0;
        chk("stray_emit_in_wait", 64'(col_ready), 64'd0);
        chk("stray_emit_no_rv", 64'(result_valid), 64'd0);
        finish_done(13'h0DD, 2);

        // Reset mid-frame
        send_frame(10, 1'b0, 1, 0, 0, 0, 1'b0, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", 64'(col_ready), 64'd1);
        chk("midrst_bmp_zero", 64'(bmp_out == '0), 64'd1);
        chk("midrst_pop_zero", 64'(pop_count), 64'd0);
        w0 = wren_cnt;
        send_frame(24, 1'b1, 2, 33, 1, 0, 1'b0, model_pc(2, 33, 24), 1'b1);
        finish_done(13'h0EE, 0);
        chk("midrst_one_wren", 64'(wren_cnt - w0), 64'd1);

        // Random gaps over 100 frames
        for (int f = 0; f < 100; f++) begin
            ncols = int'($urandom_range(COLS, 1));
            last  = (ncols < COLS) ? 1'b1 : 1'($urandom_range(1, 0));
            send_frame(ncols, last, 2, 1000 + f, 2, 0, (ncols < COLS),
                       model_pc(2, 1000 + f, ncols), 1'b1);
            finish_done(13'($urandom), int'($urandom_range(3, 0)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", 64'(q_frm.size() + q_res.size()), 64'd0);
        chk("wren_rv_balance", 64'(wren_cnt), 64'(rv_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bmp_assembler
`default_nettype wire
